// File: rtl/led_arbiter_if.sv
// Bus between the LED arbiter and its requesters: request levels, per-requester
// LED patterns, and the arbiter's grant, done pulses and LED drive.
interface led_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic [7:0]        leds;

  // Requester side: drives requests and patterns, observes the arbiter.
  modport master (
    output req,
    output data,
    input  grant,
    input  done,
    input  leds
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  data,
    output grant,
    output done,
    output leds
  );
endinterface

// File: rtl/led_arbiter.sv
// Round-robin arbiter that lends an 8-LED bank to one requester at a time for
// a slot of up to 2^HOLD_BITS cycles. The owner's pattern is shown (active-low)
// while it holds the slot; between owners the bank shows IDLE_PATTERN.
// All outputs are registered; there is no combinational input-to-output path.
module led_arbiter #(
  parameter int         NREQ         = 4,
  parameter int         HOLD_BITS    = 24,
  parameter logic [7:0] IDLE_PATTERN = 8'b10101010
) (
  input  logic          clock,
  input  logic          resetn,
  led_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [NREQ-1:0]      done_q, done_d;
  logic [HOLD_BITS-1:0] timer_q, timer_d;
  logic [7:0]           leds_q, leds_d;
  // Index of the most recently granted requester; while in HOLD it is also
  // the index of the current owner, since it updates on the granting edge.
  logic [IDX_W-1:0]     last_q, last_d;

  // Per-requester pattern view of the packed data bus.
  logic [7:0] data_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign data_arr[gi] = bus.data[8*gi +: 8];
  end

  // Round-robin pick: scan from last+1 upward with wrap. Scanning the offsets
  // from far to near lets the nearest requesting index overwrite the others.
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] cand_idx;

  // Next owner selection from the current request vector.
  always_comb begin
    sel_idx   = last_q;
    sel_valid = 1'b0;
    cand      = '0;
    cand_idx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = {1'b0, last_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NREQ)) begin
        cand = cand - (IDX_W+1)'(NREQ);
      end
      cand_idx = cand[IDX_W-1:0];
      if (bus.req[cand_idx]) begin
        sel_idx   = cand_idx;
        sel_valid = 1'b1;
      end
    end
  end

  // The owner still wants the LEDs; only its own request bit matters in HOLD.
  logic owner_req;
  assign owner_req = |(bus.req & grant_q);

  logic slot_expired;
  assign slot_expired = (timer_q == {HOLD_BITS{1'b1}});

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    timer_d = timer_q;
    leds_d  = leds_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        leds_d  = IDLE_PATTERN;
        grant_d = '0;
        if (sel_valid) begin
          grant_d = NREQ'(1) << sel_idx;
          timer_d = '0;
          last_d  = sel_idx;
          state_d = HOLD;
        end
      end
      HOLD: begin
        // Live tracking of the owner's pattern, inverted for active-low LEDs.
        leds_d  = ~data_arr[last_q];
        timer_d = timer_q + 1'b1;
        // Expiry and request drop share one exit, so they can never produce
        // two done pulses even when they coincide.
        if (slot_expired || !owner_req) begin
          done_d  = grant_q;
          grant_d = '0;
          timer_d = '0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        leds_d  = IDLE_PATTERN;
        grant_d = '0;
        state_d = IDLE;
      end
      default: begin
        leds_d  = IDLE_PATTERN;
        grant_d = '0;
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset leaves requester 0 first in line.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      timer_q <= '0;
      leds_q  <= IDLE_PATTERN;
      last_q  <= IDX_W'(NREQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      timer_q <= timer_d;
      leds_q  <= leds_d;
      last_q  <= last_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = done_q;
  assign bus.leds  = leds_q;

endmodule
